// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: requester handshakes, clear control and the registered memory write bus.
// The arbiter takes the slave modport; pixel writers and the memory side together act as master.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 6,
  parameter int COLOR_W = 12,
  parameter int SRC_W   = $clog2(NUM_REQ + 1)
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic                       clear_start;
  logic [COLOR_W-1:0]         clear_color;
  logic                       clear_busy;
  logic                       clear_done;
  logic                       fb_ready;
  logic                       wr_en;
  logic [COORD_W-1:0]         wr_x;
  logic [COORD_W-1:0]         wr_y;
  logic [COLOR_W-1:0]         wr_color;
  logic [SRC_W-1:0]           wr_src;

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_start, clear_color, fb_ready,
    output req_ready, clear_busy, clear_done, wr_en, wr_x, wr_y, wr_color, wr_src
  );

  modport master (
    output req_valid, req_x, req_y, req_color, clear_start, clear_color, fb_ready,
    input  req_ready, clear_busy, clear_done, wr_en, wr_x, wr_y, wr_color, wr_src
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin framebuffer write arbiter with a priority full-screen clear sweep; write bus is 1-cycle registered.
// Nothing issues in a cycle with fb_ready low: req_ready stays low and the clear counters hold.
module fb_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 6,
  parameter int COLOR_W = 12,
  parameter int SRC_W   = $clog2(NUM_REQ + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  fb_write_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   last;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [NUM_REQ-1:0] ready_w;
  logic               xfer;
  logic               clr_issue;
  logic               clr_last;

  logic [COORD_W-1:0] cx, cy;
  logic [COLOR_W-1:0] clr_color_q;

  logic               wr_en_q;
  logic [COORD_W-1:0] wr_x_q, wr_y_q;
  logic [COLOR_W-1:0] wr_color_q;
  logic [SRC_W-1:0]   wr_src_q;
  logic               clear_done_q;

  // Requester index k places after base, wrapping at NUM_REQ.
  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld && bus.req_valid[rr_idx(last, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(last, k);
      end
    end
  end

  always_comb begin
    ready_w = '0;
    if (state == IDLE && bus.fb_ready && grant_vld)
      ready_w[grant_idx] = 1'b1;
  end

  assign xfer      = |ready_w;
  assign clr_issue = (state == CLEAR) && bus.fb_ready;
  assign clr_last  = clr_issue && (&cx) && (&cy);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clear_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last         <= SRC_W'(NUM_REQ - 1);
      cx           <= '0;
      cy           <= '0;
      clr_color_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_color_q   <= '0;
      wr_src_q     <= '0;
      clear_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      clear_done_q <= 1'b0;
      if (xfer) begin
        last       <= grant_idx;
        wr_en_q    <= 1'b1;
        wr_x_q     <= bus.req_x[grant_idx*COORD_W +: COORD_W];
        wr_y_q     <= bus.req_y[grant_idx*COORD_W +: COORD_W];
        wr_color_q <= bus.req_color[grant_idx*COLOR_W +: COLOR_W];
        wr_src_q   <= grant_idx;
      end else if (clr_issue) begin
        wr_en_q      <= 1'b1;
        wr_x_q       <= cx;
        wr_y_q       <= cy;
        wr_color_q   <= clr_color_q;
        wr_src_q     <= SRC_W'(NUM_REQ);
        clear_done_q <= clr_last;
        // Raster order, x fastest; both counters wrap back to 0 after the last pixel.
        cx <= cx + 1'b1;
        if (&cx) cy <= cy + 1'b1;
      end
      // Colour is only captured when a clear actually starts, so mid-clear pulses are ignored.
      if (state == IDLE && bus.clear_start) begin
        clr_color_q <= bus.clear_color;
        cx          <= '0;
        cy          <= '0;
      end
    end
  end

  assign bus.req_ready  = ready_w;
  assign bus.clear_busy = (state == CLEAR);
  assign bus.clear_done = clear_done_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_x       = wr_x_q;
  assign bus.wr_y       = wr_y_q;
  assign bus.wr_color   = wr_color_q;
  assign bus.wr_src     = wr_src_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: single writes, round-robin, backpressure, full clears, reset mid-clear.
module tb_fb_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int COORD_W = 6;
  localparam int COLOR_W = 12;
  localparam int SRC_W   = 2;

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  fb_write_arbiter_if #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .SRC_W(SRC_W)) bus ();

  fb_write_arbiter #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .SRC_W(SRC_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, c, errs, done_cnt, rdy_errs;
    logic [1:0] exp_rdy;
    logic       prev_fb;

    resetn          = 1'b0;
    bus.req_valid   = '0;
    bus.req_x       = '0;
    bus.req_y       = '0;
    bus.req_color   = '0;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    bus.fb_ready    = 1'b0;
    #2;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_x", bus.wr_x, 0);
    check("rst_wr_y", bus.wr_y, 0);
    check("rst_wr_color", bus.wr_color, 0);
    check("rst_wr_src", bus.wr_src, 0);
    check("rst_clear_busy", bus.clear_busy, 0);
    check("rst_clear_done", bus.clear_done, 0);
    tick();
    tick();
    resetn = 1'b1;

    // Single requester write
    bus.fb_ready  = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_x     = {6'd0, 6'd5};
    bus.req_y     = {6'd0, 6'd7};
    bus.req_color = {12'h000, 12'hFF0};
    #1;
    check("single_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    check("single_wr_en", bus.wr_en, 1);
    check("single_wr_x", bus.wr_x, 5);
    check("single_wr_y", bus.wr_y, 7);
    check("single_wr_color", bus.wr_color, 12'hFF0);
    check("single_wr_src", bus.wr_src, 0);
    tick();
    check("single_no_more_wr", bus.wr_en, 0);
    check("single_hold_x", bus.wr_x, 5);

    // Round-robin: last grant was 0, so requester 1 goes first
    bus.req_valid = 2'b11;
    bus.req_x     = {6'd20, 6'd10};
    bus.req_y     = {6'd21, 6'd11};
    bus.req_color = {12'h222, 12'h111};
    for (int i = 0; i < 6; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      check("rr_ready", bus.req_ready, exp_rdy);
      tick();
      check("rr_wr_en", bus.wr_en, 1);
      check("rr_wr_src", bus.wr_src, (i % 2 == 0) ? 1 : 0);
      check("rr_wr_x", bus.wr_x, (i % 2 == 0) ? 20 : 10);
    end

    // Backpressure: pointer stays at 0, so requester 1 is next
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", bus.req_ready, 2'b00);
      tick();
      check("bp_wr_en", bus.wr_en, 0);
    end
    bus.fb_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    check("bp_release_src", bus.wr_src, 1);
    tick();

    // Full clear with colour 000; requesters kept valid throughout
    bus.clear_start = 1'b1;
    bus.clear_color = 12'h000;
    #1;
    check("clr_busy_before", bus.clear_busy, 0);
    tick();
    bus.clear_start = 1'b0;
    bus.req_valid   = 2'b11;
    check("clr_busy", bus.clear_busy, 1);
    check("clr_first_gap", bus.wr_en, 0);
    errs = 0; done_cnt = 0; rdy_errs = 0;
    for (int i = 0; i < 4096; i++) begin
      if (bus.req_ready !== 2'b00) rdy_errs++;
      tick();
      if (bus.wr_en !== 1'b1 || bus.wr_x !== 6'(i % 64) || bus.wr_y !== 6'(i / 64) ||
          bus.wr_color !== 12'h000 || bus.wr_src !== 2'd2) errs++;
      if (bus.clear_done === 1'b1) done_cnt++;
      if (bus.clear_done !== (i == 4095)) errs++;
    end
    check("clr_pixel_errs", errs, 0);
    check("clr_done_count", done_cnt, 1);
    check("clr_ready_low", rdy_errs, 0);
    check("clr_busy_after", bus.clear_busy, 0);
    check("clr_post_ready", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    tick();
    check("clr_post_wr_en", bus.wr_en, 0);
    check("clr_post_done", bus.clear_done, 0);

    // Clear with stalls, a colliding transfer, and a second clear_start mid-sweep
    bus.req_valid   = 2'b01;
    bus.req_x       = {6'd0, 6'd33};
    bus.req_y       = {6'd0, 6'd44};
    bus.req_color   = {12'h000, 12'hABC};
    bus.clear_start = 1'b1;
    bus.clear_color = 12'hF0F;
    #1;
    check("coll_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid   = 2'b00;
    bus.clear_start = 1'b0;
    check("coll_wr_x", bus.wr_x, 33);
    check("coll_wr_src", bus.wr_src, 0);
    n = 0; errs = 0; done_cnt = 0;
    for (c = 0; c < 10000 && n < 4096; c++) begin
      prev_fb         = (c % 2 == 0);
      bus.fb_ready    = prev_fb;
      bus.clear_start = (c == 50);
      bus.clear_color = (c == 50) ? 12'h123 : 12'hF0F;
      tick();
      if (bus.wr_en !== prev_fb) errs++;
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_x !== 6'(n % 64) || bus.wr_y !== 6'(n / 64) ||
            bus.wr_color !== 12'hF0F || bus.wr_src !== 2'd2) errs++;
        if (bus.clear_done !== (n == 4095)) errs++;
        n++;
      end
      if (bus.clear_done === 1'b1) done_cnt++;
    end
    bus.clear_start = 1'b0;
    bus.fb_ready    = 1'b1;
    check("stall_write_count", n, 4096);
    check("stall_errs", errs, 0);
    check("stall_done_count", done_cnt, 1);
    tick();
    check("stall_post_wr_en", bus.wr_en, 0);
    check("stall_post_busy", bus.clear_busy, 0);

    // Reset after 100 clear writes
    bus.clear_start = 1'b1;
    bus.clear_color = 12'h0AA;
    tick();
    bus.clear_start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.wr_en === 1'b1) n++;
    end
    check("rmc_writes_before", n, 100);
    resetn = 1'b0;
    #1;
    check("rmc_wr_en", bus.wr_en, 0);
    check("rmc_wr_x", bus.wr_x, 0);
    check("rmc_wr_y", bus.wr_y, 0);
    check("rmc_wr_color", bus.wr_color, 0);
    check("rmc_wr_src", bus.wr_src, 0);
    check("rmc_busy", bus.clear_busy, 0);
    check("rmc_done", bus.clear_done, 0);
    tick();
    resetn = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("rmc_first_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    check("rmc_wr_src_after", bus.wr_src, 0);
    check("rmc_wr_en_after", bus.wr_en, 1);
    check("rmc_done_after", bus.clear_done, 0);
    tick();
    check("rmc_idle_wr_en", bus.wr_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
